cache_2way_ctrl: RTL and testbench

- Parametrised 2-way set-associative, write-through, write-allocate cache controller with true-LRU replacement. Sized to replace the single direct data-path cache.
- Sits between the CPU load/store stage and the multicycle pipelined main memory.
- Owns its tag, valid, LRU and data storage internally.
- Burst-fills whole blocks.
- Exposes saturating hit and miss counters for performance measurement.

---
 rtl/cache_2way_ctrl_if.sv | 34 +++
 rtl/cache_2way_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cache_2way_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_2way_ctrl_if.sv
// CPU-side and memory-side buses of the 2-way cache controller.
// The slave modport is the controller's view; the master modport is the CPU/memory side.
interface cache_2way_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              cpu_req;
   logic              cpu_wr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;
   logic              cpu_done;
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;

   modport slave (
      input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall, cpu_done,
      output mem_en, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata, mem_rvalid
   );

   modport master (
      output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall, cpu_done,
      input  mem_en, mem_wr, mem_addr, mem_wdata,
      output mem_rdata, mem_rvalid
   );
endinterface

// File: rtl/cache_2way_ctrl.sv
// 2-way set-associative write-through/write-allocate cache with true LRU and burst fill.
// Load hit completes 2 cycles after acceptance; the CPU is stalled until cpu_done.
module cache_2way_ctrl #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int SETS   = 64,
   parameter int WORDS  = 8,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   cache_2way_ctrl_if.slave bus,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);
   localparam int OFF   = $clog2(WORDS);
   localparam int IDX   = $clog2(SETS);
   localparam int TAG_W = ADDR_W - 1 - OFF - IDX;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_FILL, S_MEMWR, S_DONE} state_t;

   state_t              r_state;
   logic [ADDR_W-1:1]   r_addr;
   logic                r_wr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_first;
   logic                r_way;
   logic [OFF:0]        r_iss;
   logic [OFF-1:0]      r_rcv;
   logic [SETS-1:0]     r_val0, r_val1, r_lru;
   logic [TAG_W-1:0]    r_tag0 [SETS];
   logic [TAG_W-1:0]    r_tag1 [SETS];
   logic [DATA_W-1:0]   r_data [2*SETS*WORDS];
   logic                r_mem_en, r_mem_wr, r_cpu_done;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata, r_cpu_rdata;
   logic [CNT_W-1:0]    r_hit_cnt, r_miss_cnt;

   logic [OFF-1:0]      w_off;
   logic [IDX-1:0]      w_idx;
   logic [TAG_W-1:0]    w_tag;
   logic                w_hit0, w_hit1, w_hit, w_victim;
   logic                w_fill_we, w_fill_last, w_store_we;
   logic [OFF+IDX:0]    w_rd_ptr, w_wr_ptr;

   assign w_off       = r_addr[OFF:1];
   assign w_idx       = r_addr[OFF+IDX:OFF+1];
   assign w_tag       = r_addr[ADDR_W-1:OFF+IDX+1];
   assign w_hit0      = r_val0[w_idx] && (r_tag0[w_idx] == w_tag);
   assign w_hit1      = r_val1[w_idx] && (r_tag1[w_idx] == w_tag);
   assign w_hit       = w_hit0 || w_hit1;
   // r_lru holds the least-recently-used way; invalid ways are always filled first
   assign w_victim    = !r_val0[w_idx] ? 1'b0 : (!r_val1[w_idx] ? 1'b1 : r_lru[w_idx]);
   assign w_fill_we   = (r_state == S_FILL) && bus.mem_rvalid;
   assign w_fill_last = w_fill_we && (r_rcv == '1);
   assign w_store_we  = (r_state == S_LOOKUP) && w_hit && r_wr;
   assign w_rd_ptr    = {w_hit1, w_idx, w_off};
   assign w_wr_ptr    = w_fill_we ? {r_way, w_idx, r_rcv} : w_rd_ptr;

   assign bus.cpu_stall = (r_state == S_LOOKUP) || (r_state == S_FILL) || (r_state == S_MEMWR);
   assign bus.cpu_done  = r_cpu_done;
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_wr    = r_mem_wr;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign hit_cnt       = r_hit_cnt;
   assign miss_cnt      = r_miss_cnt;

   // Data and tag storage carry no reset; validity is tracked by r_val0/r_val1.
   always_ff @(posedge clk) begin
      if (w_fill_we || w_store_we)
         r_data[w_wr_ptr] <= w_fill_we ? bus.mem_rdata : r_wdata;
      if (w_fill_last) begin
         if (r_way) r_tag1[w_idx] <= w_tag;
         else       r_tag0[w_idx] <= w_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_wr        <= 1'b0;
         r_wdata     <= '0;
         r_first     <= 1'b0;
         r_way       <= 1'b0;
         r_iss       <= '0;
         r_rcv       <= '0;
         r_val0      <= '0;
         r_val1      <= '0;
         r_lru       <= '0;
         r_mem_en    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cpu_done  <= 1'b0;
         r_cpu_rdata <= '0;
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
      end else begin
         r_cpu_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.cpu_req) begin
                  r_addr  <= bus.cpu_addr[ADDR_W-1:1];
                  r_wr    <= bus.cpu_wr;
                  r_wdata <= bus.cpu_wdata;
                  r_first <= 1'b1;
                  r_state <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               r_first <= 1'b0;
               if (w_hit) begin
                  r_lru[w_idx] <= ~w_hit1;
                  if (r_first && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                  if (r_wr) begin
                     r_mem_en    <= 1'b1;
                     r_mem_wr    <= 1'b1;
                     r_mem_addr  <= {r_addr, 1'b0};
                     r_mem_wdata <= r_wdata;
                     r_state     <= S_MEMWR;
                  end else begin
                     r_cpu_rdata <= r_data[w_rd_ptr];
                     r_cpu_done  <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end else begin
                  if (r_first && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                  r_way <= w_victim;
                  if (w_victim) r_val1[w_idx] <= 1'b0;
                  else          r_val0[w_idx] <= 1'b0;
                  r_mem_en   <= 1'b1;
                  r_mem_wr   <= 1'b0;
                  r_mem_addr <= {w_tag, w_idx, {OFF{1'b0}}, 1'b0};
                  r_iss      <= (OFF+1)'(1);
                  r_rcv      <= '0;
                  r_state    <= S_FILL;
               end
            end
            S_FILL: begin
               // r_iss counts reads already on the bus; its top bit means all WORDS issued
               if (!r_iss[OFF]) begin
                  r_mem_addr <= {w_tag, w_idx, r_iss[OFF-1:0], 1'b0};
                  r_iss      <= r_iss + (OFF+1)'(1);
               end else begin
                  r_mem_en <= 1'b0;
               end
               if (w_fill_we) begin
                  r_rcv <= r_rcv + OFF'(1);
                  if (w_fill_last) begin
                     if (r_way) r_val1[w_idx] <= 1'b1;
                     else       r_val0[w_idx] <= 1'b1;
                     r_state <= S_LOOKUP;
                  end
               end
            end
            S_MEMWR: begin
               r_mem_en   <= 1'b0;
               r_mem_wr   <= 1'b0;
               r_cpu_done <= 1'b1;
               r_state    <= S_DONE;
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cache_2way_ctrl.sv
// Directed bench for cache_2way_ctrl: cache/memory reference model, per-cycle compare process,
// fixed-latency memory responder and hand-computed literal expectations.
module tb_cache_2way_ctrl;
   localparam int ADDR_W = 16, DATA_W = 16, SETS = 64, WORDS = 8, CNT_W = 16;
   localparam int OFF = 3, IDX = 6, LAT = 3;

   logic clk = 1'b0;
   logic rst_n;
   logic [CNT_W-1:0] hit_cnt, miss_cnt;
   always #5 clk = ~clk;

   cache_2way_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
   cache_2way_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

   int n_chk = 0, n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // memory: responder contents follow DUT writes, gold follows the model
   logic [DATA_W-1:0] mem_arr [32768];
   logic [DATA_W-1:0] gold    [32768];
   logic              pv [LAT];
   logic [DATA_W-1:0] pd [LAT];

   always @(negedge clk) begin
      bus.mem_rvalid = pv[LAT-1];
      bus.mem_rdata  = pd[LAT-1];
      for (int i = LAT - 1; i > 0; i--) begin
         pv[i] = pv[i-1];
         pd[i] = pd[i-1];
      end
      pv[0] = bus.mem_en && !bus.mem_wr;
      pd[0] = bus.mem_en ? mem_arr[bus.mem_addr[15:1]] : '0;
      if (bus.mem_en && bus.mem_wr) mem_arr[bus.mem_addr[15:1]] = bus.mem_wdata;
   end

   // reference model
   typedef struct { bit wr; int addr; int wdata; } mop_t;
   mop_t exp_q[$];
   bit   m_val [2][SETS];
   int   m_tag [2][SETS];
   bit   m_lru [SETS];
   int   m_hits, m_misses;
   bit   pending = 0, exp_load;
   int   start, exp_lat, last_lat;
   logic [DATA_W-1:0] exp_rdata;
   int   rd_seen, wr_seen, first_rd, last_wr_addr, last_wr_data;

   task automatic model_clear();
      for (int s = 0; s < SETS; s++) begin
         m_val[0][s] = 0; m_val[1][s] = 0; m_lru[s] = 0;
      end
      m_hits = 0; m_misses = 0; pending = 0;
      exp_q.delete();
   endtask

   task automatic model_req(input bit wr, input int addr, input int wdata);
      int idx, tag, base, way;
      idx  = (addr >> (OFF + 1)) % SETS;
      tag  = addr >> (OFF + IDX + 1);
      base = addr & ~(2 * WORDS - 1);
      way  = -1;
      for (int w = 0; w < 2; w++)
         if (m_val[w][idx] && m_tag[w][idx] == tag) way = w;
      if (way >= 0) begin
         if (m_hits < 65535) m_hits++;
         exp_lat = wr ? 3 : 2;
      end else begin
         if (m_misses < 65535) m_misses++;
         way = !m_val[0][idx] ? 0 : (!m_val[1][idx] ? 1 : int'(m_lru[idx]));
         m_val[way][idx] = 1;
         m_tag[way][idx] = tag;
         for (int k = 0; k < WORDS; k++) exp_q.push_back('{0, base + 2 * k, 0});
         exp_lat = WORDS + 3 + LAT + (wr ? 1 : 0);
      end
      m_lru[idx] = (way == 0);
      if (wr) begin
         exp_q.push_back('{1, addr & ~1, wdata});
         gold[addr >> 1] = wdata[15:0];
      end
      exp_load  = !wr;
      exp_rdata = gold[addr >> 1];
   endtask

   // compare process
   always @(negedge clk) begin
      mop_t op;
      bit   exp_stall;
      if (rst_n) begin
         exp_stall = pending && (cyc > start) && (cyc - start < exp_lat);
         chk("cpu_stall", bus.cpu_stall, exp_stall);
         if (bus.mem_en) begin
            if (exp_q.size() == 0) chk("mem_en_unexpected", bus.mem_en, 0);
            else begin
               op = exp_q.pop_front();
               chk("mem_wr", bus.mem_wr, op.wr);
               chk("mem_addr", bus.mem_addr, op.addr);
               if (op.wr) chk("mem_wdata", bus.mem_wdata, op.wdata);
            end
            if (!bus.mem_wr) begin
               if (rd_seen == 0) first_rd = bus.mem_addr;
               rd_seen++;
            end else begin
               wr_seen++;
               last_wr_addr = bus.mem_addr;
               last_wr_data = bus.mem_wdata;
            end
         end else begin
            chk("mem_wr_idle", bus.mem_wr, 0);
         end
         if (bus.cpu_done) begin
            chk("done_expected", pending, 1);
            last_lat = cyc - start;
            chk("done_latency", last_lat, exp_lat);
            if (exp_load) chk("cpu_rdata", bus.cpu_rdata, exp_rdata);
            chk("hit_cnt", hit_cnt, m_hits);
            chk("miss_cnt", miss_cnt, m_misses);
            chk("mem_ops_left", exp_q.size(), 0);
            pending = 0;
         end
      end
   end

   task automatic issue(input bit wr, input int addr, input int wdata);
      model_req(wr, addr, wdata);
      rd_seen = 0; wr_seen = 0;
      bus.cpu_wr    = wr;
      bus.cpu_addr  = addr[15:0];
      bus.cpu_wdata = wdata[15:0];
      bus.cpu_req   = 1'b1;
      start   = cyc;
      pending = 1;
   endtask

   task automatic req(input bit wr, input int addr, input int wdata);
      int n = 0;
      issue(wr, addr, wdata);
      do begin
         @(negedge clk);
         n++;
      end while (!bus.cpu_done && n < 200);
      if (!bus.cpu_done) begin
         chk("done_timeout", bus.cpu_done, 1);
         pending = 0;
      end
      bus.cpu_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_cpu_done"}, bus.cpu_done, 0);
      chk({tag, "_cpu_stall"}, bus.cpu_stall, 0);
      chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
      chk({tag, "_mem_en"}, bus.mem_en, 0);
      chk({tag, "_mem_wr"}, bus.mem_wr, 0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
      chk({tag, "_hit_cnt"}, hit_cnt, 0);
      chk({tag, "_miss_cnt"}, miss_cnt, 0);
   endtask

   task automatic reset_and_release();
      rst_n = 1'b0;
      bus.cpu_req = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, n;
      for (int i = 0; i < 32768; i++) begin
         mem_arr[i] = 16'(i * 2) ^ 16'hC300;
         gold[i]    = mem_arr[i];
      end
      for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
      bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2 check_all_zero("reset");
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: cold read miss
      req(0, 'h0010, 0);
      chk("t1_rdata", bus.cpu_rdata, 16'hC310);
      chk("t1_reads", rd_seen, 8);
      chk("t1_first_rd", first_rd, 16'h0010);
      chk("t1_miss_cnt", miss_cnt, 1);
      chk("t1_latency", last_lat, 14);

      // 2: read hit
      req(0, 'h0014, 0);
      chk("t2_rdata", bus.cpu_rdata, 16'hC314);
      chk("t2_traffic", rd_seen + wr_seen, 0);
      chk("t2_hit_cnt", hit_cnt, 1);
      chk("t2_latency", last_lat, 2);

      // 3: store hit, then load back
      req(1, 'h0012, 'hBEEF);
      chk("t3_wr_addr", last_wr_addr, 16'h0012);
      chk("t3_wr_data", last_wr_data, 16'hBEEF);
      chk("t3_reads", rd_seen, 0);
      chk("t3_latency", last_lat, 3);
      req(0, 'h0012, 0);
      chk("t3_load_rdata", bus.cpu_rdata, 16'hBEEF);
      chk("t3_load_traffic", rd_seen + wr_seen, 0);

      // 4: LRU eviction in set 1
      req(0, 'h0010, 0);
      req(0, 'h0410, 0);
      chk("t4_0410_reads", rd_seen, 8);
      req(0, 'h0410, 0);
      req(0, 'h0810, 0);
      chk("t4_0810_first_rd", first_rd, 16'h0810);
      req(0, 'h0410, 0);
      chk("t4_0410_hit_traffic", rd_seen, 0);
      req(0, 'h0010, 0);
      chk("t4_0010_reads", rd_seen, 8);
      chk("t4_rdata", bus.cpu_rdata, 16'hC310);
      chk("t4_miss_cnt", miss_cnt, 4);
      chk("t4_hit_cnt", hit_cnt, 6);

      // 5: store miss with write-allocate on a cold cache
      reset_and_release();
      req(1, 'h2000, 'h1234);
      chk("t5_first_rd", first_rd, 16'h2000);
      chk("t5_reads", rd_seen, 8);
      chk("t5_wr_addr", last_wr_addr, 16'h2000);
      chk("t5_wr_data", last_wr_data, 16'h1234);
      chk("t5_latency", last_lat, 15);
      req(0, 'h2000, 0);
      chk("t5_load_rdata", bus.cpu_rdata, 16'h1234);
      chk("t5_load_traffic", rd_seen + wr_seen, 0);
      chk("t5_hit_cnt", hit_cnt, 1);
      chk("t5_miss_cnt", miss_cnt, 1);

      // 6: reset after the third fill beat, then replay the same load
      issue(0, 'h0010, 0);
      b = 0; n = 0;
      while (b < 3 && n < 100) begin
         @(posedge clk);
         if (bus.mem_rvalid) b++;
         n++;
      end
      chk("t6_beats_before_reset", b, 3);
      #2 rst_n = 1'b0;
      #1 check_all_zero("t6_reset");
      bus.cpu_req = 1'b0;
      model_clear();
      @(negedge clk);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      req(0, 'h0010, 0);
      chk("t6_reads", rd_seen, 8);
      chk("t6_miss_cnt", miss_cnt, 1);
      chk("t6_hit_cnt", hit_cnt, 0);
      chk("t6_rdata", bus.cpu_rdata, 16'hC310);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
